// File: rtl/counter_drv_pkg.sv
// Shared types and constants for the counter stimulus sequencer and its command FIFO.
package counter_drv_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] arg;
  } cmd_t;

  localparam logic       IDLE_LD_CNT_N  = 1'b1;
  localparam logic       IDLE_UPDN      = 1'b0;
  localparam logic       IDLE_COUNT_ENB = 1'b0;
  localparam logic [7:0] IDLE_DATA_IN   = 8'h00;

  // LOAD always lasts one cycle; a zero count means a full 256-cycle run.
  function automatic logic [8:0] cmd_cycles(input cmd_t c);
    if (c.op == OP_LOAD) return 9'd1;
    return (c.arg == 8'd0) ? 9'd256 : {1'b0, c.arg};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO of commands with registered full/empty flags.
module cmd_fifo
  import counter_drv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // NOTE: payload storage is not reset; pointers and flags alone define validity, so it maps to plain storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/counter_drv_seq.sv
// Command-driven sequencer for the 8-bit up/down counter, with a cycle-accurate
// mirror of data_out and a sticky, saturating mismatch checker.
module counter_drv_seq
  import counter_drv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       ld_cnt_,
  output logic       updn_cnt,
  output logic       count_enb,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] exp_out,
  output logic       mismatch,
  output logic [7:0] mismatch_cnt
);

  state_e     state;
  state_e     state_nxt;
  logic [8:0] rem;
  logic [8:0] rem_nxt;
  logic       ld_nxt;
  logic       updn_nxt;
  logic       enb_nxt;
  logic [7:0] din_nxt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       last_cycle;
  logic       start;
  cmd_t       wr_cmd;
  cmd_t       head;

  assign wr_cmd = '{op: op_e'(cmd_op), arg: cmd_arg};

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push    (cmd_valid),
    .wr_data (wr_cmd),
    .pop     (start),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready  = !fifo_full;
  assign busy       = (state == DRIVE);
  assign last_cycle = (state == DRIVE) && (rem == 9'd1);
  // Popping on the last driven cycle chains queued commands without a gap.
  assign start      = !fifo_empty && ((state == IDLE) || last_cycle);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    ld_nxt    = ld_cnt_;
    updn_nxt  = updn_cnt;
    enb_nxt   = count_enb;
    din_nxt   = data_in;
    if (start) begin
      state_nxt = DRIVE;
      rem_nxt   = cmd_cycles(head);
      ld_nxt    = IDLE_LD_CNT_N;
      updn_nxt  = IDLE_UPDN;
      enb_nxt   = IDLE_COUNT_ENB;
      din_nxt   = IDLE_DATA_IN;
      case (head.op)
        OP_LOAD: begin
          ld_nxt  = 1'b0;
          din_nxt = head.arg;
        end
        OP_UP: begin
          enb_nxt  = 1'b1;
          updn_nxt = 1'b1;
        end
        OP_DOWN: enb_nxt = 1'b1;
        default: ;
      endcase
    end else if (last_cycle) begin
      state_nxt = IDLE;
      ld_nxt    = IDLE_LD_CNT_N;
      updn_nxt  = IDLE_UPDN;
      enb_nxt   = IDLE_COUNT_ENB;
      din_nxt   = IDLE_DATA_IN;
    end else if (state == DRIVE) begin
      rem_nxt = rem - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      rem       <= '0;
      ld_cnt_   <= IDLE_LD_CNT_N;
      updn_cnt  <= IDLE_UPDN;
      count_enb <= IDLE_COUNT_ENB;
      data_in   <= IDLE_DATA_IN;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      ld_cnt_   <= ld_nxt;
      updn_cnt  <= updn_nxt;
      count_enb <= enb_nxt;
      data_in   <= din_nxt;
      done      <= last_cycle;
    end
  end

  // Mirror of the counter and checker: both see the pre-edge controls and data_out.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      exp_out      <= 8'h00;
      mismatch     <= 1'b0;
      mismatch_cnt <= 8'h00;
    end else begin
      if (!ld_cnt_)       exp_out <= data_in;
      else if (count_enb) exp_out <= updn_cnt ? exp_out + 8'd1 : exp_out - 8'd1;
      if (data_out != exp_out) begin
        mismatch <= 1'b1;
        if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_counter_drv_seq.sv
// Self-checking bench: a behavioural counter answers the sequencer, and a
// command-level model predicts the exp_out trajectory, busy/done timing and backpressure.
module tb_counter_drv_seq;
  import counter_drv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic       ld_cnt_;
  logic       updn_cnt;
  logic       count_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic [7:0] exp_out;
  logic       mismatch;
  logic [7:0] mismatch_cnt;

  logic [7:0] cnt;
  logic       fault_en = 1'b0;
  logic [7:0] fault_val = 8'h00;
  logic [7:0] model_val = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         bp_ready_low;
  int         bp_push_cyc[$];

  counter_drv_seq #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .ld_cnt_      (ld_cnt_),
    .updn_cnt     (updn_cnt),
    .count_enb    (count_enb),
    .data_in      (data_in),
    .data_out     (data_out),
    .busy         (busy),
    .done         (done),
    .exp_out      (exp_out),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  // The counter under check, with an override used to inject faults.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)          cnt <= 8'h00;
    else if (!ld_cnt_)  cnt <= data_in;
    else if (count_enb) cnt <= updn_cnt ? cnt + 8'd1 : cnt - 8'd1;
  end
  assign data_out = fault_en ? fault_val : cnt;

  function automatic cmd_t mk(input op_e op, input logic [7:0] arg);
    cmd_t c;
    c.op  = op;
    c.arg = arg;
    return c;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_      = 1'b0;
    cmd_valid = 1'b0;
    fault_en  = 1'b0;
    repeat (2) @(negedge clk);
    rst_      = 1'b1;
    model_val = 8'h00;
  endtask

  task automatic push_cmd(input op_e op, input logic [7:0] arg);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: cmd_ready got 0 expected 1 within 1000 cycles");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Feeds commands as fast as accepted and checks the exp_out trajectory cycle by cycle.
  task automatic run_seq(input string name, input cmd_t cmds[$]);
    logic [7:0] exp_q[$];
    logic [7:0] v;
    logic [7:0] e;
    int         n, idx, cyc, limit, exp_busy, busy_cycles, busy_runs, done_cnt;
    logic       prev_busy, ready_seen, finished;
    v = model_val;
    exp_busy = 0;
    foreach (cmds[i]) begin
      if (cmds[i].op == OP_LOAD) n = 1;
      else n = (cmds[i].arg == 8'd0) ? 256 : int'(cmds[i].arg);
      for (int k = 0; k < n; k++) begin
        case (cmds[i].op)
          OP_LOAD: v = cmds[i].arg;
          OP_UP:   v = v + 8'd1;
          OP_DOWN: v = v - 8'd1;
          default: ;
        endcase
        exp_q.push_back(v);
      end
      exp_busy += n;
    end
    idx = 0; cyc = 0; busy_cycles = 0; busy_runs = 0; done_cnt = 0;
    prev_busy = 1'b0; ready_seen = 1'b0; finished = 1'b0;
    bp_ready_low = 0;
    bp_push_cyc.delete();
    limit = exp_busy + 4 * cmds.size() + 20;
    while (!finished && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cmd_valid && ready_seen) begin
        bp_push_cyc.push_back(cyc);
        idx++;
      end
      if (prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_busy: got busy cycle beyond %0d expected none", name, exp_busy);
        end else begin
          e = exp_q.pop_front();
          if (exp_out !== e) begin
            errors++;
            $display("FAIL %s exp_out@%0d: got %02h expected %02h", name, cyc, exp_out, e);
          end
        end
      end
      if (busy === 1'b1) busy_cycles++;
      if (busy === 1'b1 && !prev_busy) busy_runs++;
      if (done === 1'b1) done_cnt++;
      if (idx < cmds.size() && !cmd_ready) bp_ready_low++;
      prev_busy = (busy === 1'b1);
      if (idx < cmds.size()) begin
        cmd_valid = 1'b1;
        cmd_op    = cmds[idx].op;
        cmd_arg   = cmds[idx].arg;
      end else begin
        cmd_valid = 1'b0;
      end
      ready_seen = cmd_ready;
      finished = (idx == cmds.size()) && !prev_busy && (exp_q.size() == 0);
    end
    cmd_valid = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: got unfinished after %0d cycles expected completion", name, cyc);
    end
    checks++;
    if (busy_cycles != exp_busy || busy_runs != 1) begin
      errors++;
      $display("FAIL %s busy: got %0d cycles in %0d runs expected %0d in 1", name, busy_cycles, busy_runs, exp_busy);
    end
    checks++;
    if (done_cnt != cmds.size()) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected %0d", name, done_cnt, cmds.size());
    end
    checks++;
    if (exp_out !== v || data_out !== v) begin
      errors++;
      $display("FAIL %s final: got exp_out=%02h data_out=%02h expected %02h", name, exp_out, data_out, v);
    end
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL %s mismatch: got %b expected 0", name, mismatch);
    end
    model_val = v;
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    obs = {ld_cnt_, count_enb, updn_cnt, data_in, cmd_ready, busy, done, exp_out, mismatch, mismatch_cnt};
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    end
    rst_ = 1'b1;
    model_val = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_out !== 8'h00 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b exp_out=%02h mismatch=%b expected 0/00/0", busy, exp_out, mismatch);
    end
  endtask

  task automatic test_load_up();
    cmd_t q[$];
    q.push_back(mk(OP_LOAD, 8'hA5));
    q.push_back(mk(OP_UP, 8'd3));
    run_seq("load_up", q);
  endtask

  task automatic test_wrap();
    cmd_t q[$];
    q.push_back(mk(OP_LOAD, 8'hFF));
    q.push_back(mk(OP_UP, 8'd1));
    run_seq("wrap_up", q);
    q.delete();
    q.push_back(mk(OP_LOAD, 8'h00));
    q.push_back(mk(OP_DOWN, 8'd1));
    run_seq("wrap_down", q);
    q.delete();
    q.push_back(mk(OP_LOAD, 8'h7E));
    q.push_back(mk(OP_HOLD, 8'd5));
    run_seq("hold", q);
  endtask

  task automatic test_backpressure();
    cmd_t q[$];
    q.push_back(mk(OP_HOLD, 8'd0));
    q.push_back(mk(OP_LOAD, 8'h33));
    q.push_back(mk(OP_UP, 8'd2));
    q.push_back(mk(OP_DOWN, 8'd3));
    q.push_back(mk(OP_HOLD, 8'd2));
    q.push_back(mk(OP_UP, 8'd1));
    run_seq("backpressure", q);
    // HOLD pops one edge after its push and runs 256 cycles; the queue fills four edges after it.
    checks++;
    if (bp_push_cyc.size() != 6) begin
      errors++;
      $display("FAIL bp_pushes: got %0d expected 6", bp_push_cyc.size());
    end else begin
      if (bp_push_cyc[4] - bp_push_cyc[0] != 4) begin
        errors++;
        $display("FAIL bp_fill: got %0d expected 4", bp_push_cyc[4] - bp_push_cyc[0]);
      end
      checks++;
      if (bp_push_cyc[5] - bp_push_cyc[0] != 258) begin
        errors++;
        $display("FAIL bp_fifth_accept: got %0d expected 258", bp_push_cyc[5] - bp_push_cyc[0]);
      end
    end
    checks++;
    if (bp_ready_low != 253) begin
      errors++;
      $display("FAIL bp_ready_low: got %0d expected 253", bp_ready_low);
    end
  endtask

  task automatic test_random();
    cmd_t       q[$];
    logic [1:0] op_bits;
    op_e        op;
    for (int r = 0; r < 5; r++) begin
      q.delete();
      for (int c = 0; c < int'($urandom_range(3, 7)); c++) begin
        op_bits = 2'($urandom_range(0, 3));
        op = op_e'(op_bits);
        if (op == OP_LOAD) q.push_back(mk(op, 8'($urandom_range(0, 255))));
        else               q.push_back(mk(op, 8'($urandom_range(1, 6))));
      end
      run_seq("random", q);
    end
  endtask

  task automatic test_fault();
    int n = 0;
    apply_reset();
    push_cmd(OP_LOAD, 8'h10);
    push_cmd(OP_UP, 8'd4);
    while (count_enb !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL fault_up_start: got count_enb=%b expected 1 within 50 cycles", count_enb);
    end
    // The counter now shows 11..14 on successive cycles; hold data_out at 10 for those four.
    @(negedge clk);
    fault_val = 8'h10;
    fault_en  = 1'b1;
    repeat (4) @(negedge clk);
    fault_en = 1'b0;
    checks++;
    if (mismatch !== 1'b1 || mismatch_cnt !== 8'd4 || exp_out !== 8'h14) begin
      errors++;
      $display("FAIL fault: got mismatch=%b cnt=%0d exp_out=%02h expected 1/4/14", mismatch, mismatch_cnt, exp_out);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (mismatch !== 1'b1 || mismatch_cnt !== 8'd4) begin
      errors++;
      $display("FAIL fault_after_release: got mismatch=%b cnt=%0d expected 1/4", mismatch, mismatch_cnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    fault_val = 8'h55;
    fault_en  = 1'b1;
    repeat (254) @(negedge clk);
    checks++;
    if (mismatch_cnt !== 8'd254) begin
      errors++;
      $display("FAIL sat_254: got %0d expected 254", mismatch_cnt);
    end
    @(negedge clk);
    checks++;
    if (mismatch_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_255: got %0d expected 255", mismatch_cnt);
    end
    repeat (45) @(negedge clk);
    fault_en = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (mismatch_cnt !== 8'd255 || mismatch !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got cnt=%0d mismatch=%b expected 255/1", mismatch_cnt, mismatch);
    end
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if (mismatch_cnt !== 8'd0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL sat_reset: got cnt=%0d mismatch=%b expected 0/0", mismatch_cnt, mismatch);
    end
    @(negedge clk);
    rst_ = 1'b1;
    model_val = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs;
    int          n = 0;
    int          busy_seen = 0;
    apply_reset();
    push_cmd(OP_LOAD, 8'h20);
    push_cmd(OP_UP, 8'd200);
    push_cmd(OP_HOLD, 8'd3);
    push_cmd(OP_DOWN, 8'd3);
    push_cmd(OP_HOLD, 8'd3);
    while (count_enb !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    obs = {ld_cnt_, count_enb, updn_cnt, data_in, cmd_ready, busy, done, exp_out, mismatch, mismatch_cnt};
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset_state: got %h expected %h", obs,
               {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    end
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    model_val = 8'h00;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || count_enb !== 1'b0 || ld_cnt_ !== 1'b1) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || exp_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_flushed: got %0d active cycles exp_out=%02h expected 0/00", busy_seen, exp_out);
    end
  endtask

  initial begin
    test_reset();
    test_load_up();
    test_wrap();
    test_backpressure();
    test_random();
    test_fault();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
